// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between N_REQ byte producers
//
// Purpose:
//   Grants one requester at a time, forwards its byte to uart_tx as a single
//   Wishbone classic write, and pulses ack_o back to that requester when
//   uart_tx acknowledges. A requester holding lock_i when its byte completes
//   keeps the grant so that multi-byte messages are not interleaved.
//
// Ports:
//   clk_i     - clock
//   rst_i     - synchronous active-high reset
//   req_i     - per-requester send request, held with stable data until ack_o
//   lock_i    - per-requester lock, sampled when a byte completes
//   dat_i     - requester k data in bits [k*DAT_WIDTH +: DAT_WIDTH]
//   ack_o     - one-cycle pulse, byte from requester k accepted by uart_tx
//   grant_o   - one-hot current owner, zero when no owner
//   wb_cyc_o  - Wishbone cycle to uart_tx
//   wb_stb_o  - Wishbone strobe (same flop as wb_cyc_o)
//   wb_we_o   - Wishbone write enable (same flop as wb_cyc_o)
//   wb_dat_o  - byte to transmit
//   wb_ack_i  - ack from uart_tx

module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DAT_WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ-1:0]           lock_i,
    input  logic [N_REQ*DAT_WIDTH-1:0] dat_i,
    output logic [N_REQ-1:0]           ack_o,
    output logic [N_REQ-1:0]           grant_o,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    output logic                       wb_we_o,
    output logic [DAT_WIDTH-1:0]       wb_dat_o,
    input  logic                       wb_ack_i
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE,
        S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic                 cyc_q, cyc_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;
    // Index of the most recent grant; doubles as the current owner index
    // while grant_q is non-zero.
    logic [IW-1:0]        last_q, last_d;

    logic [DAT_WIDTH-1:0] dat_arr [N_REQ];
    logic                 pick_vld;
    logic [IW-1:0]        pick_idx;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign dat_arr[k] = dat_i[k*DAT_WIDTH +: DAT_WIDTH];
    end

    // Round-robin search: first set request starting just after last_q,
    // wrapping modulo N_REQ, so the last winner has lowest priority.
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_w;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        idx_w    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx   = (int'(last_q) + i) % N_REQ;
            idx_w = IW'(idx);
            if (!pick_vld && req_i[idx_w]) begin
                pick_vld = 1'b1;
                pick_idx = idx_w;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = '0;
        cyc_d   = cyc_q;
        dat_d   = dat_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = N_REQ'(1) << pick_idx;
                    dat_d   = dat_arr[pick_idx];
                    cyc_d   = 1'b1;
                    last_d  = pick_idx;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                // Requests are not looked at here; the byte always runs to completion.
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    ack_d   = grant_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // One dead cycle lets the owner drop req_i in response to ack_o
                // without it being mistaken for a new request.
                if (lock_i[last_q]) begin
                    state_d = S_HOLD;
                end else begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (req_i[last_q]) begin
                    dat_d   = dat_arr[last_q];
                    cyc_d   = 1'b1;
                    state_d = S_XFER;
                end else if (!lock_i[last_q]) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                cyc_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            cyc_q   <= 1'b0;
            dat_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            cyc_q   <= cyc_d;
            dat_q   <= dat_d;
            last_q  <= last_d;
        end
    end

    assign ack_o    = ack_q;
    assign grant_o  = grant_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = cyc_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int FR = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [3:0]   lock = '0;
    logic [31:0]  dat = '0;
    logic [3:0]   ack_o, grant_o;
    logic         wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]   wb_dat_o;
    logic         wb_ack_i;
    logic         vec_ack = 1'b0;
    logic         auto_ack = 1'b0;
    logic         use_auto = 1'b0;
    logic         mon_en = 1'b0;
    int           errors = 0;
    int           checks = 0;
    logic [7:0]   sent_q[$];

    assign wb_ack_i = use_auto ? auto_ack : vec_ack;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .DAT_WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .dat_i(dat),
        .ack_o(ack_o), .grant_o(grant_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i)
    );

    // uart_tx stand-in: acks FR cycles after a cycle starts.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (wb_cyc_o && !rst) begin
                if (cnt == FR - 1) begin auto_ack = 1'b1; cnt = 0; end
                else begin auto_ack = 1'b0; cnt++; end
            end else begin
                auto_ack = 1'b0; cnt = 0;
            end
        end
    end

    // Cycle-by-cycle invariants and a log of completed bytes.
    initial begin
        logic [3:0] pg, pa;
        logic       pc;
        logic [7:0] pd;
        logic       bad;
        pg = '0; pa = '0; pc = 1'b0; pd = '0;
        forever begin
            @(posedge clk); #1;
            if (mon_en) begin
                bad = 1'b0;
                if (!$onehot0(grant_o)) bad = 1'b1;
                if (wb_cyc_o && grant_o == 0) bad = 1'b1;
                if (wb_stb_o != wb_cyc_o || wb_we_o != wb_cyc_o) bad = 1'b1;
                if (!$onehot0(ack_o)) bad = 1'b1;
                if (ack_o != 0 && pa != 0) bad = 1'b1;
                if ((ack_o & ~pg) != 0) bad = 1'b1;
                if (pc && wb_cyc_o && wb_dat_o != pd) bad = 1'b1;
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL invariant t=%0t grant=%b ack=%b cyc=%b dat=%h prev_grant=%b prev_ack=%b prev_dat=%h",
                             $time, grant_o, ack_o, wb_cyc_o, wb_dat_o, pg, pa, pd);
                end
                if (pc && !wb_cyc_o && ack_o != 0) sent_q.push_back(pd);
            end
            pg = grant_o; pa = ack_o; pc = wb_cyc_o; pd = wb_dat_o;
        end
    end

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] dat;
        logic        wack;
        logic [3:0]  g;
        logic [3:0]  a;
        logic        c;
        logic [7:0]  w;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic wait_ack(input string nm, input logic [3:0] hold_g, output logic [3:0] a);
        logic bad;
        bad = 1'b0;
        a = '0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (hold_g != 0 && grant_o != hold_g) bad = 1'b1;
            if (ack_o != 0) begin
                a = ack_o;
                break;
            end
        end
        if (a == 0) begin
            errors++; checks++;
            $display("FAIL %s_timeout: got no ack_o within 200 cycles expected an ack", nm);
        end
        if (hold_g != 0) chk({nm, "_grant_held"}, {31'd0, bad}, 32'd0);
    endtask

    initial begin
        logic [3:0] a;
        logic       bad;
        logic [7:0] exp_b[4];
        //            rst  req    lock   dat            wack  g      a      c     w
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 32'hA3A2A155, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 4'h1, 4'h0, 32'hA3A2A155, 1'b0, 4'h1, 4'h0, 1'b1, 8'h55};
        tbl[2]  = '{1'b0, 4'h1, 4'h0, 32'hA3A2A155, 1'b0, 4'h1, 4'h0, 1'b1, 8'h55};
        tbl[3]  = '{1'b0, 4'h1, 4'h0, 32'hA3A2A155, 1'b1, 4'h1, 4'h1, 1'b0, 8'h55};
        tbl[4]  = '{1'b0, 4'h0, 4'h0, 32'hA3A2A155, 1'b0, 4'h0, 4'h0, 1'b0, 8'h55};
        tbl[5]  = '{1'b1, 4'h0, 4'h0, 32'hB3A2B1A0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 4'h5, 4'h0, 32'hB3A2B1A0, 1'b0, 4'h1, 4'h0, 1'b1, 8'hA0};
        tbl[7]  = '{1'b0, 4'h5, 4'h0, 32'hB3A2B1A0, 1'b1, 4'h1, 4'h1, 1'b0, 8'hA0};
        tbl[8]  = '{1'b0, 4'h4, 4'h0, 32'hB3A2B1A0, 1'b0, 4'h0, 4'h0, 1'b0, 8'hA0};
        tbl[9]  = '{1'b0, 4'h4, 4'h0, 32'hB3A2B1A0, 1'b0, 4'h4, 4'h0, 1'b1, 8'hA2};
        tbl[10] = '{1'b0, 4'hE, 4'h0, 32'hB3A2B1A0, 1'b0, 4'h4, 4'h0, 1'b1, 8'hA2};
        tbl[11] = '{1'b0, 4'h4, 4'h0, 32'hB3A2B1A0, 1'b1, 4'h4, 4'h4, 1'b0, 8'hA2};
        tbl[12] = '{1'b0, 4'h0, 4'h0, 32'hB3A2B1A0, 1'b0, 4'h0, 4'h0, 1'b0, 8'hA2};
        tbl[13] = '{1'b0, 4'h0, 4'h1, 32'hB3A2B1A0, 1'b0, 4'h0, 4'h0, 1'b0, 8'hA2};
        tbl[14] = '{1'b0, 4'h2, 4'h1, 32'hB3A2B1A0, 1'b0, 4'h2, 4'h0, 1'b1, 8'hB1};
        tbl[15] = '{1'b0, 4'h2, 4'h1, 32'hB3A2B1A0, 1'b1, 4'h2, 4'h2, 1'b0, 8'hB1};
        tbl[16] = '{1'b0, 4'h0, 4'h0, 32'hB3A2B1A0, 1'b0, 4'h0, 4'h0, 1'b0, 8'hB1};

        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; lock = tbl[i].lock;
            dat = tbl[i].dat; vec_ack = tbl[i].wack;
            tick();
            mon_en = 1'b1;
            checks++;
            if (grant_o !== tbl[i].g || ack_o !== tbl[i].a || wb_cyc_o !== tbl[i].c ||
                wb_dat_o !== tbl[i].w) begin
                errors++;
                $display("FAIL vec%0d: got grant=%b ack=%b cyc=%b dat=%h expected grant=%b ack=%b cyc=%b dat=%h",
                         i, grant_o, ack_o, wb_cyc_o, wb_dat_o, tbl[i].g, tbl[i].a, tbl[i].c, tbl[i].w);
            end
        end
        vec_ack = 1'b0;
        use_auto = 1'b1;

        // Round robin with all four requests held: order 0,1,2,3,0,1,2,3.
        do_reset();
        dat = 32'h33221100; req = 4'hF; lock = 4'h0;
        for (int i = 0; i < 8; i++) begin
            wait_ack("rr", 4'h0, a);
            chk($sformatf("rr_ack%0d", i), {28'd0, a}, 32'd1 << (i % 4));
        end
        req = 4'h0; tick(); tick();

        // Locked message from requester 1 while requester 0 waits.
        do_reset();
        sent_q.delete();
        dat = 32'h00004830; req = 4'h2; lock = 4'h2;
        tick();
        chk("lock_first_grant", {28'd0, grant_o}, 32'h2);
        req = 4'h3;
        wait_ack("lock_b0", 4'h2, a);
        chk("lock_ack0", {28'd0, a}, 32'h2);
        dat[15:8] = 8'h49;
        wait_ack("lock_b1", 4'h2, a);
        chk("lock_ack1", {28'd0, a}, 32'h2);
        dat[15:8] = 8'h21;
        wait_ack("lock_b2", 4'h2, a);
        chk("lock_ack2", {28'd0, a}, 32'h2);
        req = 4'h1; lock = 4'h0;
        tick();
        chk("lock_release_grant", {28'd0, grant_o}, 32'h0);
        tick();
        chk("lock_next_grant", {23'd0, wb_cyc_o, grant_o, wb_dat_o[3:0]}, {23'd0, 1'b1, 4'h1, 4'h0});
        wait_ack("lock_r0", 4'h1, a);
        chk("lock_r0_ack", {28'd0, a}, 32'h1);
        req = 4'h0; tick();
        exp_b = '{8'h48, 8'h49, 8'h21, 8'h30};
        chk("lock_sent_count", sent_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < sent_q.size(); i++)
            chk($sformatf("lock_sent%0d", i), {24'd0, sent_q[i]}, {24'd0, exp_b[i]});

        // Reset in the middle of a transfer.
        do_reset();
        dat = 32'h00005A00; req = 4'h2; lock = 4'h0;
        tick();
        chk("rst_xfer_start", {31'd0, wb_cyc_o}, 32'd1);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("rst_outputs", {15'd0, ack_o, grant_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_dat_o},
            32'd0);
        rst = 1'b0;
        tick();
        chk("rst_regrant", {19'd0, wb_cyc_o, grant_o, wb_dat_o}, {19'd0, 1'b1, 4'h2, 8'h5A});
        wait_ack("rst_after", 4'h2, a);
        chk("rst_after_ack", {28'd0, a}, 32'h2);
        req = 4'h0; tick(); tick();

        // Locked owner idles in HOLD while requester 3 waits.
        do_reset();
        dat = 32'h99007700; req = 4'h2; lock = 4'h2;
        wait_ack("hold_b0", 4'h0, a);
        chk("hold_ack0", {28'd0, a}, 32'h2);
        req = 4'h8;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wb_cyc_o || grant_o != 4'h2) bad = 1'b1;
        end
        chk("hold_20_cycles", {31'd0, bad}, 32'd0);
        lock = 4'h0;
        tick();
        chk("hold_release", {27'd0, wb_cyc_o, grant_o}, 32'd0);
        tick();
        chk("hold_req3_grant", {19'd0, wb_cyc_o, grant_o, wb_dat_o}, {19'd0, 1'b1, 4'h8, 8'h99});
        wait_ack("hold_r3", 4'h8, a);
        chk("hold_r3_ack", {28'd0, a}, 32'h8);
        req = 4'h0; tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
